// File: rtl/ctrl_word_pipe.sv
// Control-word pipeline with per-stage stall/flush, bubble insertion and pending-write mask.
// Optional saturating perf counters are enabled with `define CWP_PERF_CNT_EN.
module ctrl_word_pipe #(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [WORD_W-1:0]            in_word,
    input  logic [4:0]                   in_dest,
    input  logic                         in_load_regfile,
    output logic                         in_ready,
    input  logic [NUM_STAGES-1:0]        stall,
    input  logic [NUM_STAGES-1:0]        flush,
    output logic [NUM_STAGES-1:0]        stage_valid,
    output logic [NUM_STAGES*WORD_W-1:0] stage_word,
    output logic                         out_valid,
    output logic [WORD_W-1:0]            out_word,
    output logic [4:0]                   out_dest,
    output logic                         out_load_regfile,
    output logic [31:0]                  busy_mask,
    output logic [CNT_W-1:0]             perf_stall_cnt,
    output logic [CNT_W-1:0]             perf_flush_cnt,
    output logic [CNT_W-1:0]             perf_bubble_cnt
);

    localparam int unsigned LAST = NUM_STAGES - 1;

    logic [NUM_STAGES-1:0] valid_q, valid_d;
    logic [NUM_STAGES-1:0] lrf_q, lrf_d;
    logic [WORD_W-1:0]     word_q [NUM_STAGES];
    logic [WORD_W-1:0]     word_d [NUM_STAGES];
    logic [4:0]            dest_q [NUM_STAGES];
    logic [4:0]            dest_d [NUM_STAGES];
    logic [NUM_STAGES-1:0] hold;
    logic [NUM_STAGES-1:0] kill;

    // A stall or flush at an older stage reaches every younger stage.
    always_comb begin
        hold = '0;
        kill = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            hold[i] = |(stall >> i);
            kill[i] = |(flush >> i);
        end
    end

    assign in_ready = ~hold[0] & ~(|flush);

    // Next-state: kill beats hold; a stage whose predecessor holds receives a zeroed bubble.
    always_comb begin
        valid_d = valid_q;
        lrf_d   = lrf_q;
        word_d  = word_q;
        dest_d  = dest_q;
        if (kill[0]) begin
            valid_d[0] = 1'b0;
            lrf_d[0]   = 1'b0;
            word_d[0]  = '0;
            dest_d[0]  = '0;
        end else if (!hold[0]) begin
            valid_d[0] = in_valid;
            lrf_d[0]   = in_valid & in_load_regfile;
            word_d[0]  = in_valid ? in_word : '0;
            dest_d[0]  = in_valid ? in_dest : 5'd0;
        end
        for (int i = 1; i < NUM_STAGES; i++) begin
            if (kill[i] || (!hold[i] && hold[i-1])) begin
                valid_d[i] = 1'b0;
                lrf_d[i]   = 1'b0;
                word_d[i]  = '0;
                dest_d[i]  = '0;
            end else if (!hold[i]) begin
                valid_d[i] = valid_q[i-1];
                lrf_d[i]   = lrf_q[i-1];
                word_d[i]  = word_q[i-1];
                dest_d[i]  = dest_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            lrf_q   <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                word_q[i] <= '0;
                dest_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            lrf_q   <= lrf_d;
            word_q  <= word_d;
            dest_q  <= dest_d;
        end
    end

    // Invalid stages always carry zeroed fields, so the retire fields come straight from flops.
    always_comb begin
        stage_word = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            stage_word[i*WORD_W +: WORD_W] = word_q[i];
        end
    end

    assign stage_valid      = valid_q;
    assign out_valid        = valid_q[LAST];
    assign out_word         = word_q[LAST];
    assign out_dest         = dest_q[LAST];
    assign out_load_regfile = lrf_q[LAST];

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (valid_q[i] && lrf_q[i]) begin
                busy_mask[dest_q[i]] = 1'b1;
            end
        end
        busy_mask[0] = 1'b0;
    end

`ifdef CWP_PERF_CNT_EN
    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt  <= '0;
            perf_flush_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if ((|stall) && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
            end
            if ((|flush) && (perf_flush_cnt != '1)) begin
                perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
            end
            if (!valid_q[LAST] && (perf_bubble_cnt != '1)) begin
                perf_bubble_cnt <= perf_bubble_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign perf_stall_cnt  = '0;
    assign perf_flush_cnt  = '0;
    assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_ctrl_word_pipe.sv
// Randomized bench for ctrl_word_pipe against a stage-index reference model.
module tb_ctrl_word_pipe;

    localparam int unsigned NS = 4;
    localparam int unsigned WW = 16;
    localparam int unsigned CW = 4;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [WW-1:0]     in_word;
    logic [4:0]        in_dest;
    logic              in_load_regfile;
    logic              in_ready;
    logic [NS-1:0]     stall;
    logic [NS-1:0]     flush;
    logic [NS-1:0]     stage_valid;
    logic [NS*WW-1:0]  stage_word;
    logic              out_valid;
    logic [WW-1:0]     out_word;
    logic [4:0]        out_dest;
    logic              out_load_regfile;
    logic [31:0]       busy_mask;
    logic [CW-1:0]     perf_stall_cnt;
    logic [CW-1:0]     perf_flush_cnt;
    logic [CW-1:0]     perf_bubble_cnt;

    ctrl_word_pipe #(.WORD_W(WW), .NUM_STAGES(NS), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_word(in_word), .in_dest(in_dest),
        .in_load_regfile(in_load_regfile), .in_ready(in_ready),
        .stall(stall), .flush(flush),
        .stage_valid(stage_valid), .stage_word(stage_word),
        .out_valid(out_valid), .out_word(out_word), .out_dest(out_dest),
        .out_load_regfile(out_load_regfile), .busy_mask(busy_mask),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
        .perf_bubble_cnt(perf_bubble_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: one entry per stage, index 0 youngest.
    bit          m_v [NS];
    logic [15:0] m_w [NS];
    logic [4:0]  m_d [NS];
    bit          m_l [NS];
    int          m_sc, m_fc, m_bc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int top_idx(input logic [NS-1:0] v);
        int r = -1;
        for (int k = 0; k < NS; k++) if (v[k]) r = k;
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NS; k++) begin
            m_v[k] = 0; m_w[k] = '0; m_d[k] = '0; m_l[k] = 0;
        end
        m_sc = 0; m_fc = 0; m_bc = 0;
    endtask

    // Stages up to the oldest flush die, stages up to the oldest stall freeze,
    // the stage just above the freeze gets a bubble, everything older shifts.
    task automatic model_step();
        int sidx = top_idx(stall);
        int fidx = top_idx(flush);
        bit          nv [NS];
        logic [15:0] nw [NS];
        logic [4:0]  nd [NS];
        bit          nl [NS];
        if (stall != '0 && m_sc < CNT_MAX) m_sc++;
        if (flush != '0 && m_fc < CNT_MAX) m_fc++;
        if (!m_v[NS-1] && m_bc < CNT_MAX) m_bc++;
        for (int k = 0; k < NS; k++) begin
            if (k <= fidx) begin
                nv[k] = 0; nw[k] = '0; nd[k] = '0; nl[k] = 0;
            end else if (k <= sidx) begin
                nv[k] = m_v[k]; nw[k] = m_w[k]; nd[k] = m_d[k]; nl[k] = m_l[k];
            end else if (k == 0) begin
                nv[k] = in_valid;
                nw[k] = in_valid ? in_word : 16'h0;
                nd[k] = in_valid ? in_dest : 5'd0;
                nl[k] = in_valid && in_load_regfile;
            end else if (k == sidx + 1) begin
                nv[k] = 0; nw[k] = '0; nd[k] = '0; nl[k] = 0;
            end else begin
                nv[k] = m_v[k-1]; nw[k] = m_w[k-1]; nd[k] = m_d[k-1]; nl[k] = m_l[k-1];
            end
        end
        m_v = nv; m_w = nw; m_d = nd; m_l = nl;
    endtask

    task automatic check_all();
        logic [63:0] ew = '0;
        logic [3:0]  evld = '0;
        logic [31:0] ebusy = '0;
        logic        erdy;
        int es, ef, eb;
        for (int k = 0; k < NS; k++) begin
            ew[k*WW +: WW] = m_w[k];
            evld[k] = m_v[k];
            if (m_v[k] && m_l[k] && m_d[k] != 5'd0) ebusy[m_d[k]] = 1'b1;
        end
        erdy = (stall == '0) && (flush == '0);
`ifdef CWP_PERF_CNT_EN
        es = m_sc; ef = m_fc; eb = m_bc;
`else
        es = 0; ef = 0; eb = 0;
`endif
        check("stage_valid", 64'(stage_valid), 64'(evld));
        check("stage_word", 64'(stage_word), ew);
        check("out_valid", 64'(out_valid), 64'(m_v[NS-1]));
        check("out_word", 64'(out_word), 64'(m_w[NS-1]));
        check("out_dest", 64'(out_dest), 64'(m_d[NS-1]));
        check("out_lrf", 64'(out_load_regfile), 64'(m_l[NS-1] && m_v[NS-1]));
        check("busy_mask", 64'(busy_mask), 64'(ebusy));
        check("in_ready", 64'(in_ready), 64'(erdy));
        check("perf_stall", 64'(perf_stall_cnt), 64'(es));
        check("perf_flush", 64'(perf_flush_cnt), 64'(ef));
        check("perf_bubble", 64'(perf_bubble_cnt), 64'(eb));
    endtask

    function automatic logic [NS-1:0] rand_bits(input int pct);
        logic [NS-1:0] v = '0;
        for (int k = 0; k < NS; k++) v[k] = ($urandom_range(99) < pct);
        return v;
    endfunction

    // Called just after a falling edge: apply inputs, check, advance model, wait next falling edge.
    task automatic cycle(input logic [NS-1:0] st, input logic [NS-1:0] fl, input int vpct);
        int sel = $urandom_range(2);
        stall           = st;
        flush           = fl;
        in_valid        = ($urandom_range(99) < vpct);
        in_word         = 16'($urandom);
        in_dest         = (sel == 0) ? 5'd0 : (sel == 1) ? 5'd5 : 5'($urandom);
        in_load_regfile = ($urandom_range(3) != 0);
        #1;
        check_all();
        model_step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; in_word = '0; in_dest = '0; in_load_regfile = 1'b0;
        stall = '0; flush = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check_all();
        rst = 1'b1;

        repeat (30) cycle('0, '0, 90);
        repeat (200) cycle(rand_bits(10), rand_bits(4), 80);
        repeat (20) cycle(4'b1000, '0, 80);
        repeat (40) cycle(rand_bits(15), '0, 100);

        // Asynchronous reset between clock edges.
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("async_stage_valid", 64'(stage_valid), 64'd0);
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_out_word", 64'(out_word), 64'd0);
        check("async_busy", 64'(busy_mask), 64'd0);
        @(negedge clk);
        in_valid = 1'b0; stall = '0; flush = '0;
        #1;
        check_all();
        rst = 1'b1;

        repeat (150) cycle(rand_bits(10), rand_bits(5), 75);
        repeat (10) cycle('0, '0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
